traffic_light_monitor: RTL and testbench

- Observer and checker on the receiving end of the red/yellow/green lamp outputs of the traffic light controller.
- Samples the lamp lines every clk and counts slow ticks per phase.
- Checks the lamp code is one-hot, the phase order is R->G->Y->R and each phase lasts its programmed tick count.
- Reports sticky error flags, lock status, current phase, dwell count and completed-cycle count. Used in both the bench and silicon self-check.

---
 rtl/traffic_light_monitor.sv | 178 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive observer of the red/yellow/green lamp lines of a traffic light
// controller. It decodes the lamp code every clk, counts slow ticks per
// phase, and raises sticky flags for non-one-hot codes, illegal phase order
// (legal order is R->G->Y->R) and wrong phase durations. Every output is a
// register, so nothing flows combinationally from the inputs to the outputs.
module traffic_light_monitor #(
    parameter int RED_DURATION    = 5,
    parameter int GREEN_DURATION  = 5,
    parameter int YELLOW_DURATION = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic             locked,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_sequence,
    output logic             err_duration,
    output logic             err_any
);

    // ACQUIRE: not yet synchronised, durations are not checked.
    // TRACK: a legal transition has been seen, durations are checked.
    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_NONE   = 2'b11
    } phase_t;

    localparam logic [CNT_W-1:0] DUR_RED    = CNT_W'(RED_DURATION);
    localparam logic [CNT_W-1:0] DUR_GREEN  = CNT_W'(GREEN_DURATION);
    localparam logic [CNT_W-1:0] DUR_YELLOW = CNT_W'(YELLOW_DURATION);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state,      w_state_n;
    phase_t           r_phase,      w_phase_n;
    logic [CNT_W-1:0] r_dwell,      w_dwell_n;
    logic [CNT_W-1:0] r_cycle,      w_cycle_n;
    logic             r_err_onehot, w_err_onehot_n;
    logic             r_err_seq,    w_err_seq_n;
    logic             r_err_dur,    w_err_dur_n;
    logic             r_err_any;

    logic             w_valid;
    phase_t           w_lamp;
    logic             w_legal;
    logic             w_set_onehot;
    logic             w_set_seq;
    logic             w_set_dur;

    // Expected dwell of a phase; PH_NONE never gets checked.
    function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
        case (p)
            PH_RED:    dur_of = DUR_RED;
            PH_GREEN:  dur_of = DUR_GREEN;
            PH_YELLOW: dur_of = DUR_YELLOW;
            default:   dur_of = '0;
        endcase
    endfunction

    // Decode the lamp code: exactly one lamp high gives a valid phase.
    always_comb begin
        w_valid = 1'b1;
        w_lamp  = PH_NONE;
        case ({red, green, yellow})
            3'b100:  w_lamp = PH_RED;
            3'b010:  w_lamp = PH_GREEN;
            3'b001:  w_lamp = PH_YELLOW;
            default: w_valid = 1'b0;
        endcase
    end

    // Legal transitions are R->G, G->Y and Y->R only.
    always_comb begin
        w_legal = ((r_phase == PH_RED)    && (w_lamp == PH_GREEN))  ||
                  ((r_phase == PH_GREEN)  && (w_lamp == PH_YELLOW)) ||
                  ((r_phase == PH_YELLOW) && (w_lamp == PH_RED));
    end

    // Next-state logic: tracker FSM, counters and error set conditions.
    always_comb begin
        w_state_n    = r_state;
        w_phase_n    = r_phase;
        w_dwell_n    = r_dwell;
        w_cycle_n    = r_cycle;
        w_set_onehot = 1'b0;
        w_set_seq    = 1'b0;
        w_set_dur    = 1'b0;

        if (!w_valid) begin
            // Bad lamp code: drop synchronisation, nothing else is checked.
            w_set_onehot = 1'b1;
            w_phase_n    = PH_NONE;
            w_dwell_n    = '0;
            w_state_n    = ST_ACQUIRE;
        end else if (w_lamp == r_phase) begin
            // Phase held: count ticks; a tick at full dwell is an overrun.
            if (tick) begin
                if (r_dwell != '1) begin
                    w_dwell_n = r_dwell + CNT_ONE;
                end
                if ((r_state == ST_TRACK) && (r_dwell == dur_of(r_phase))) begin
                    w_set_dur = 1'b1;
                end
            end
        end else begin
            // Phase change: new dwell starts at 1 if it coincides with a tick.
            w_phase_n = w_lamp;
            w_dwell_n = tick ? CNT_ONE : '0;
            if (r_phase == PH_NONE) begin
                w_state_n = ST_ACQUIRE;
            end else if (w_legal) begin
                if ((r_state == ST_TRACK) && (r_dwell != dur_of(r_phase))) begin
                    w_set_dur = 1'b1;
                end
                if ((r_state == ST_TRACK) && (r_phase == PH_YELLOW)) begin
                    w_cycle_n = r_cycle + CNT_ONE;
                end
                w_state_n = ST_TRACK;
            end else begin
                w_set_seq = 1'b1;
                w_state_n = ST_ACQUIRE;
            end
        end

        // A new set condition beats a simultaneous clear.
        w_err_onehot_n = (r_err_onehot & ~clear) | w_set_onehot;
        w_err_seq_n    = (r_err_seq    & ~clear) | w_set_seq;
        w_err_dur_n    = (r_err_dur    & ~clear) | w_set_dur;
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ACQUIRE;
            r_phase      <= PH_NONE;
            r_dwell      <= '0;
            r_cycle      <= '0;
            r_err_onehot <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_dur    <= 1'b0;
            r_err_any    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_phase      <= w_phase_n;
            r_dwell      <= w_dwell_n;
            r_cycle      <= w_cycle_n;
            r_err_onehot <= w_err_onehot_n;
            r_err_seq    <= w_err_seq_n;
            r_err_dur    <= w_err_dur_n;
            r_err_any    <= w_err_onehot_n | w_err_seq_n | w_err_dur_n;
        end
    end

    assign phase        = r_phase;
    assign locked       = (r_state == ST_TRACK);
    assign dwell        = r_dwell;
    assign cycle_count  = r_cycle;
    assign err_onehot   = r_err_onehot;
    assign err_sequence = r_err_seq;
    assign err_duration = r_err_dur;
    assign err_any      = r_err_any;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor. The bench plays the role of
// the controller: it drives lamp codes and ticks (one tick every 4 clks,
// lamps change on the clk after the tick ending a phase) and compares the
// monitor outputs against hand-computed values.
module tb_traffic_light_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             red = 1'b0;
    logic             yellow = 1'b0;
    logic             green = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       phase;
    logic             locked;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] cycle_count;
    logic             err_onehot;
    logic             err_sequence;
    logic             err_duration;
    logic             err_any;

    int n_checks = 0;
    int n_errors = 0;

    traffic_light_monitor #(
        .RED_DURATION   (5),
        .GREEN_DURATION (5),
        .YELLOW_DURATION(2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .clear       (clear),
        .phase       (phase),
        .locked      (locked),
        .dwell       (dwell),
        .cycle_count (cycle_count),
        .err_onehot  (err_onehot),
        .err_sequence(err_sequence),
        .err_duration(err_duration),
        .err_any     (err_any)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clk: inputs are sampled at the edge, outputs read 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a lamp code and let one (tick-free) edge sample it.
    task automatic enter(input logic r, input logic y, input logic g);
        red    = r;
        yellow = y;
        green  = g;
        step();
    endtask

    // n ticks; the first follows first_gap idle clks, later ones 3 idle clks,
    // so that with the change edge ticks land every 4 clks.
    task automatic ticks(input int n, input int first_gap);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < ((k == 0) ? first_gap : 3); j++) step();
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    // Healthy cycle starting just after red was entered, ending on red.
    task automatic nominal_cycle();
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        ticks(5, 2);
        enter(1'b0, 1'b1, 1'b0);
        ticks(2, 2);
        enter(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_errs(input string tag, input logic o, input logic s,
                              input logic d, input logic a);
        check({tag, "_onehot"}, 32'(err_onehot), 32'(o));
        check({tag, "_seq"},    32'(err_sequence), 32'(s));
        check({tag, "_dur"},    32'(err_duration), 32'(d));
        check({tag, "_any"},    32'(err_any), 32'(a));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        red = 1'b0; yellow = 1'b0; green = 1'b0; tick = 1'b0; clear = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset values.
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_phase", 32'(phase), 32'd3);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_dwell", 32'(dwell), 32'd0);
        check("rst_cycle", 32'(cycle_count), 32'd0);
        check_errs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Nominal run: first red is not checked; lock one clk after R->G.
        enter(1'b1, 1'b0, 1'b0);
        check("n_red_phase", 32'(phase), 32'd0);
        check("n_red_locked", 32'(locked), 32'd0);
        ticks(5, 2);
        check("n_red_dwell", 32'(dwell), 32'd5);
        enter(1'b0, 1'b0, 1'b1);
        check("n_lock", 32'(locked), 32'd1);
        check("n_green_phase", 32'(phase), 32'd1);
        check("n_green_dwell0", 32'(dwell), 32'd0);
        ticks(5, 2);
        check("n_green_dwell", 32'(dwell), 32'd5);
        enter(1'b0, 1'b1, 1'b0);
        check("n_yel_phase", 32'(phase), 32'd2);
        ticks(2, 2);
        check("n_yel_dwell", 32'(dwell), 32'd2);
        enter(1'b1, 1'b0, 1'b0);
        check("n_cycle1", 32'(cycle_count), 32'd1);
        nominal_cycle();
        nominal_cycle();
        check("n_cycle3", 32'(cycle_count), 32'd3);
        check("n_locked", 32'(locked), 32'd1);
        check_errs("n", 1'b0, 1'b0, 1'b0, 1'b0);

        // Two lamps at once while tracking.
        ticks(2, 2);
        enter(1'b1, 1'b0, 1'b1);
        check("oh_flag", 32'(err_onehot), 32'd1);
        check("oh_locked", 32'(locked), 32'd0);
        check("oh_phase", 32'(phase), 32'd3);
        check("oh_dwell", 32'(dwell), 32'd0);
        check("oh_any", 32'(err_any), 32'd1);
        enter(1'b1, 1'b0, 1'b0);
        check("oh_reacq_locked", 32'(locked), 32'd0);
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        check("oh_relock", 32'(locked), 32'd1);
        check("oh_sticky", 32'(err_onehot), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("oh_cleared", 32'(err_onehot), 32'd0);
        check("oh_clr_any", 32'(err_any), 32'd0);
        check("oh_clr_locked", 32'(locked), 32'd1);
        check("oh_clr_phase", 32'(phase), 32'd1);
        check("oh_clr_cycle", 32'(cycle_count), 32'd3);

        // Illegal G->R.
        ticks(5, 2);
        enter(1'b1, 1'b0, 1'b0);
        check("seq_flag", 32'(err_sequence), 32'd1);
        check("seq_locked", 32'(locked), 32'd0);
        check("seq_any", 32'(err_any), 32'd1);
        check("seq_dur", 32'(err_duration), 32'd0);
        check("seq_cycle", 32'(cycle_count), 32'd3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("seq_cleared", 32'(err_sequence), 32'd0);

        // Clear coinciding with illegal Y->G: the set wins.
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        ticks(5, 2);
        enter(1'b0, 1'b1, 1'b0);
        ticks(2, 2);
        clear = 1'b1;
        enter(1'b0, 1'b0, 1'b1);
        check("clrset_seq", 32'(err_sequence), 32'd1);
        check("clrset_any", 32'(err_any), 32'd1);
        step();
        clear = 1'b0;
        check("clronly_seq", 32'(err_sequence), 32'd0);
        check("clronly_any", 32'(err_any), 32'd0);

        // Short green (4 ticks) while locked.
        enter(1'b0, 1'b1, 1'b0);
        ticks(2, 2);
        enter(1'b1, 1'b0, 1'b0);
        check("dur_relock", 32'(locked), 32'd1);
        check("dur_cycle4", 32'(cycle_count), 32'd4);
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        ticks(4, 2);
        check("short_before", 32'(err_duration), 32'd0);
        enter(1'b0, 1'b1, 1'b0);
        check("short_flag", 32'(err_duration), 32'd1);
        check("short_any", 32'(err_any), 32'd1);
        check("short_locked", 32'(locked), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("short_cleared", 32'(err_duration), 32'd0);

        // Long green: 6th tick raises the flag before any change.
        ticks(2, 2);
        enter(1'b1, 1'b0, 1'b0);
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        ticks(5, 2);
        check("long_at5", 32'(err_duration), 32'd0);
        ticks(1, 3);
        check("long_flag", 32'(err_duration), 32'd1);
        check("long_phase", 32'(phase), 32'd1);
        check("long_dwell", 32'(dwell), 32'd6);

        // Mid-green async reset with dwell=3 and cycle_count=2.
        do_reset();
        enter(1'b1, 1'b0, 1'b0);
        nominal_cycle();
        nominal_cycle();
        ticks(5, 2);
        enter(1'b0, 1'b0, 1'b1);
        ticks(3, 2);
        check("pre_rst_dwell", 32'(dwell), 32'd3);
        check("pre_rst_cycle", 32'(cycle_count), 32'd2);
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_phase", 32'(phase), 32'd3);
        check("arst_dwell", 32'(dwell), 32'd0);
        check("arst_cycle", 32'(cycle_count), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        check_errs("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        enter(1'b0, 1'b0, 1'b1);
        check("post_rst_phase", 32'(phase), 32'd1);
        check("post_rst_locked", 32'(locked), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
